// File: rtl/piso_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : piso_buffer_if
// Purpose  : Bundle of the parallel write side and serial read side of
//            piso_buffer. The master side is the producers and the consumer.
//            The slave side is the buffer itself.
// Revision : 1.0 - initial release
// ============================================================================
interface piso_buffer_if #(
  parameter int WIDTH  = 32,
  parameter int LENGTH = 8
);
  logic [WIDTH-1:0]          d_in [LENGTH-1:0];
  logic [LENGTH-1:0]         we;
  logic [LENGTH-1:0]         used_pos;
  logic [WIDTH-1:0]          d_out;
  logic [$clog2(LENGTH)-1:0] d_out_slot;
  logic                      d_out_valid;
  logic                      d_out_ready;
  logic                      drop;

  modport master (
    output d_in, we, d_out_ready,
    input  used_pos, d_out, d_out_slot, d_out_valid, drop
  );

  modport slave (
    input  d_in, we, d_out_ready,
    output used_pos, d_out, d_out_slot, d_out_valid, drop
  );
endinterface
`default_nettype wire

// File: rtl/piso_buffer.sv
`default_nettype none
// ============================================================================
// Module   : piso_buffer
// Purpose  : Parallel-in, serial-out buffer. Each producer owns one slot.
//            Occupied slots drain one per cycle through a registered
//            valid/ready output stage.
// Options  : PISO_ROUND_ROBIN_EN - round-robin slot selection. When this
//            macro is undefined, the lowest occupied slot index wins.
// Revision : 1.0 - initial release
// ============================================================================
module piso_buffer #(
  parameter int WIDTH  = 32,
  parameter int LENGTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  piso_buffer_if.slave   bus
);

  localparam int SW = $clog2(LENGTH);

  logic [WIDTH-1:0]  r_slot [LENGTH-1:0];
  logic [LENGTH-1:0] r_used;
  logic [WIDTH-1:0]  r_dout;
  logic [SW-1:0]     r_dout_slot;
  logic              r_valid;
  logic              r_drop;

  logic              w_load;
  logic              w_any;
  logic [SW-1:0]     w_sel;
  logic [LENGTH-1:0] w_clear;
  logic [LENGTH-1:0] w_accept;

  // The output register may take a new word when it is empty or being consumed.
  assign w_load   = !r_valid || bus.d_out_ready;
  assign w_any    = |r_used;
  // Writes only land in slots that were free before the edge.
  assign w_accept = bus.we & ~r_used;

`ifdef PISO_ROUND_ROBIN_EN
  logic [SW-1:0] r_rr_ptr;
  logic [SW:0]   w_idx;

  // Pick the first occupied slot at or after r_rr_ptr, wrapping at LENGTH.
  always_comb begin
    w_sel = '0;
    w_idx = '0;
    for (int k = LENGTH - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_rr_ptr} + (SW+1)'(k);
      if (w_idx >= (SW+1)'(LENGTH)) begin
        w_idx = w_idx - (SW+1)'(LENGTH);
      end
      if (r_used[w_idx[SW-1:0]]) begin
        w_sel = w_idx[SW-1:0];
      end
    end
  end

  // Move the priority to the slot just after the one loaded.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rr_ptr <= '0;
    end else if (w_load && w_any) begin
      r_rr_ptr <= (w_sel == SW'(LENGTH - 1)) ? '0 : w_sel + 1'b1;
    end
  end
`else
  // Use fixed priority: the lowest occupied slot index wins.
  always_comb begin
    w_sel = '0;
    for (int k = LENGTH - 1; k >= 0; k--) begin
      if (r_used[k]) begin
        w_sel = SW'(k);
      end
    end
  end
`endif

  // Build a one-hot mask of the slot that is freed when it moves to the output.
  always_comb begin
    w_clear = '0;
    if (w_load && w_any) begin
      w_clear[w_sel] = 1'b1;
    end
  end

  // Capture producer data into the free slots. Reset leaves slot contents alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LENGTH; i++) begin
        if (w_accept[i]) begin
          r_slot[i] <= bus.d_in[i];
        end
      end
    end
  end

  // Update occupancy, the drop flag and the one-entry output register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_used      <= '0;
      r_dout      <= '0;
      r_dout_slot <= '0;
      r_valid     <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      // A write to the slot being drained still sees it occupied, so that
      // write is dropped and the slot ends up free.
      r_used <= (r_used | bus.we) & ~w_clear;
      r_drop <= |(bus.we & r_used);
      if (w_load) begin
        if (w_any) begin
          r_dout      <= r_slot[w_sel];
          r_dout_slot <= w_sel;
          r_valid     <= 1'b1;
        end else begin
          r_valid     <= 1'b0;
        end
      end
    end
  end

  assign bus.used_pos    = r_used;
  assign bus.d_out       = r_dout;
  assign bus.d_out_slot  = r_dout_slot;
  assign bus.d_out_valid = r_valid;
  assign bus.drop        = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_piso_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_buffer
// Purpose  : Self-checking bench for piso_buffer. It runs directed scenarios
//            and a randomized run against a queue-level reference model.
// Options  : PISO_ROUND_ROBIN_EN selects round-robin expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piso_buffer;

  localparam int WIDTH  = 32;
  localparam int LENGTH = 8;
  localparam int SW     = $clog2(LENGTH);
`ifdef PISO_ROUND_ROBIN_EN
  localparam int FIRST_AFTER_SLOT1 = 4;
  localparam int SECOND_AFTER_SLOT1 = 0;
`else
  localparam int FIRST_AFTER_SLOT1 = 0;
  localparam int SECOND_AFTER_SLOT1 = 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  piso_buffer_if #(.WIDTH(WIDTH), .LENGTH(LENGTH)) bus ();

  piso_buffer #(.WIDTH(WIDTH), .LENGTH(LENGTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: which slots hold data, the slot contents, and the output word
  bit             m_used [LENGTH];
  logic [WIDTH-1:0] m_data [LENGTH];
  logic [WIDTH-1:0] m_out;
  int             m_slot;
  bit             m_valid;
  bit             m_drop;
  int             m_ptr;

  function automatic logic [LENGTH-1:0] m_used_vec();
    logic [LENGTH-1:0] v;
    for (int i = 0; i < LENGTH; i++) v[i] = m_used[i];
    return v;
  endfunction

  // Advance the model by one edge using the current inputs, then step the DUT
  task automatic tick();
    int pick;
    bit load;
    bit any_drop;
    if (!rst) begin
      for (int i = 0; i < LENGTH; i++) m_used[i] = 1'b0;
      m_out = '0; m_slot = 0; m_valid = 1'b0; m_drop = 1'b0; m_ptr = 0;
    end else begin
      pick = -1;
      any_drop = 1'b0;
      load = !m_valid || bus.d_out_ready;
      if (load) begin
        for (int k = 0; k < LENGTH; k++) begin
          if (pick < 0 && m_used[(m_ptr + k) % LENGTH]) pick = (m_ptr + k) % LENGTH;
        end
      end
      for (int i = 0; i < LENGTH; i++) begin
        if (bus.we[i]) begin
          if (m_used[i]) any_drop = 1'b1;
          else begin
            m_data[i] = bus.d_in[i];
            m_used[i] = 1'b1;
          end
        end
      end
      if (load) begin
        if (pick >= 0) begin
          m_out = m_data[pick];
          m_slot = pick;
          m_valid = 1'b1;
          m_used[pick] = 1'b0;
`ifdef PISO_ROUND_ROBIN_EN
          m_ptr = (pick + 1) % LENGTH;
`endif
        end else begin
          m_valid = 1'b0;
        end
      end
      m_drop = any_drop;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    bus.we = '0;
    bus.d_out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    bus.we = '1;
    for (int i = 0; i < LENGTH; i++) bus.d_in[i] = $urandom;
    bus.d_out_ready = 1'b1;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    bus.we = '0;
    checks++; if (bus.used_pos !== 8'h00) begin errors++; $display("FAIL reset_used: got %h expected 00", bus.used_pos); end
    checks++; if (bus.d_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.d_out_valid); end
    checks++; if (bus.drop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b expected 0", bus.drop); end
    checks++; if (bus.d_out !== 32'h0 || bus.d_out_slot !== 3'd0) begin errors++; $display("FAIL reset_dout: got %h/%0d expected 0/0", bus.d_out, bus.d_out_slot); end
    bus.we = 8'h01;
    bus.d_in[0] = 32'hA5A5_0001;
    tick();
    bus.we = '0;
    checks++; if (bus.used_pos !== 8'h01) begin errors++; $display("FAIL reset_next_write: got %h expected 01", bus.used_pos); end
    tick();
    checks++; if (bus.d_out_valid !== 1'b1 || bus.d_out !== 32'hA5A5_0001) begin errors++; $display("FAIL reset_next_out: got %b/%h expected 1/a5a50001", bus.d_out_valid, bus.d_out); end
    tick();
  endtask

  task automatic test_single_write();
    apply_reset();
    bus.d_out_ready = 1'b1;
    bus.we = 8'h20;
    bus.d_in[5] = 32'hDEAD_BEEF;
    tick();
    bus.we = '0;
    checks++; if (bus.used_pos !== 8'h20 || bus.d_out_valid !== 1'b0) begin errors++; $display("FAIL single_edge0: got used=%h valid=%b expected 20/0", bus.used_pos, bus.d_out_valid); end
    tick();
    checks++; if (bus.d_out_valid !== 1'b1 || bus.d_out !== 32'hDEAD_BEEF || bus.d_out_slot !== 3'd5) begin errors++; $display("FAIL single_edge1: got %b/%h/%0d expected 1/deadbeef/5", bus.d_out_valid, bus.d_out, bus.d_out_slot); end
    checks++; if (bus.used_pos !== 8'h00) begin errors++; $display("FAIL single_used_clear: got %h expected 00", bus.used_pos); end
    tick();
    checks++; if (bus.d_out_valid !== 1'b0) begin errors++; $display("FAIL single_edge2: got valid=%b expected 0", bus.d_out_valid); end
  endtask

  task automatic test_all_slots();
    apply_reset();
    bus.d_out_ready = 1'b1;
    bus.we = 8'hFF;
    for (int i = 0; i < LENGTH; i++) bus.d_in[i] = WIDTH'(i);
    tick();
    bus.we = '0;
    checks++; if (bus.used_pos !== 8'hFF) begin errors++; $display("FAIL all_used: got %h expected ff", bus.used_pos); end
    for (int k = 0; k < LENGTH; k++) begin
      tick();
      checks++;
      if (bus.d_out_valid !== 1'b1 || bus.d_out !== WIDTH'(k) || bus.d_out_slot !== SW'(k)) begin
        errors++; $display("FAIL all_beat%0d: got %b/%h/%0d expected 1/%h/%0d", k, bus.d_out_valid, bus.d_out, bus.d_out_slot, k, k);
      end
    end
    tick();
    checks++; if (bus.d_out_valid !== 1'b0) begin errors++; $display("FAIL all_end: got valid=%b expected 0", bus.d_out_valid); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    bus.d_out_ready = 1'b0;
    bus.we = 8'h44;
    bus.d_in[2] = 32'h2222_0002;
    bus.d_in[6] = 32'h6666_0006;
    tick();
    bus.we = '0;
    tick();
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (bus.d_out_valid !== 1'b1 || bus.d_out !== 32'h2222_0002 || bus.d_out_slot !== 3'd2 || bus.used_pos !== 8'h40) begin
        errors++; $display("FAIL bp_hold%0d: got %b/%h/%0d used=%h expected 1/22220002/2 used=40", c, bus.d_out_valid, bus.d_out, bus.d_out_slot, bus.used_pos);
      end
    end
    bus.d_out_ready = 1'b1;
    tick();
    checks++; if (bus.d_out_valid !== 1'b1 || bus.d_out !== 32'h6666_0006 || bus.d_out_slot !== 3'd6) begin errors++; $display("FAIL bp_release: got %b/%h/%0d expected 1/66660006/6", bus.d_out_valid, bus.d_out, bus.d_out_slot); end
    tick();
    checks++; if (bus.d_out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got valid=%b expected 0", bus.d_out_valid); end
  endtask

  task automatic test_overflow();
    apply_reset();
    bus.d_out_ready = 1'b0;
    bus.we = 8'h0A;
    bus.d_in[1] = 32'hA1A1_0001;
    bus.d_in[3] = 32'hA3A3_0003;
    tick();
    bus.we = '0;
    tick();
    bus.we = 8'h08;
    bus.d_in[3] = 32'h0000_1234;
    tick();
    bus.we = '0;
    checks++; if (bus.drop !== 1'b1 || bus.used_pos !== 8'h08) begin errors++; $display("FAIL ovf_drop: got drop=%b used=%h expected 1/08", bus.drop, bus.used_pos); end
    tick();
    checks++; if (bus.drop !== 1'b0) begin errors++; $display("FAIL ovf_pulse: got drop=%b expected 0", bus.drop); end
    bus.d_out_ready = 1'b1;
    tick();
    checks++; if (bus.d_out !== 32'hA3A3_0003 || bus.d_out_slot !== 3'd3) begin errors++; $display("FAIL ovf_data_kept: got %h/%0d expected a3a30003/3", bus.d_out, bus.d_out_slot); end
    apply_reset();
    bus.d_out_ready = 1'b1;
    bus.we = 8'h08;
    bus.d_in[3] = 32'hB0B0_0000;
    tick();
    bus.d_in[3] = 32'hB1B1_1111;
    tick();
    bus.we = '0;
    checks++; if (bus.drop !== 1'b1 || bus.used_pos !== 8'h00 || bus.d_out !== 32'hB0B0_0000) begin errors++; $display("FAIL ovf_drain_edge: got drop=%b used=%h dout=%h expected 1/00/b0b00000", bus.drop, bus.used_pos, bus.d_out); end
    tick();
    checks++; if (bus.drop !== 1'b0 || bus.d_out_valid !== 1'b0 || bus.used_pos !== 8'h00) begin errors++; $display("FAIL ovf_after: got drop=%b valid=%b used=%h expected 0/0/00", bus.drop, bus.d_out_valid, bus.used_pos); end
  endtask

  task automatic test_priority();
    apply_reset();
    bus.d_out_ready = 1'b1;
    bus.we = 8'h02;
    bus.d_in[1] = 32'hC1C1_0001;
    tick();
    bus.we = 8'h11;
    bus.d_in[0] = 32'hC0C0_0000;
    bus.d_in[4] = 32'hC4C4_0004;
    tick();
    bus.we = '0;
    checks++; if (bus.d_out_slot !== 3'd1 || bus.used_pos !== 8'h11) begin errors++; $display("FAIL prio_slot1: got slot=%0d used=%h expected 1/11", bus.d_out_slot, bus.used_pos); end
    tick();
    checks++; if (bus.d_out_slot !== SW'(FIRST_AFTER_SLOT1)) begin errors++; $display("FAIL prio_first: got slot=%0d expected %0d", bus.d_out_slot, FIRST_AFTER_SLOT1); end
    tick();
    checks++; if (bus.d_out_slot !== SW'(SECOND_AFTER_SLOT1)) begin errors++; $display("FAIL prio_second: got slot=%0d expected %0d", bus.d_out_slot, SECOND_AFTER_SLOT1); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(0, 199) != 0);
      bus.we = LENGTH'($urandom & $urandom);
      for (int i = 0; i < LENGTH; i++) bus.d_in[i] = $urandom;
      bus.d_out_ready = (n < 1000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      tick();
      checks++;
      if (bus.used_pos !== m_used_vec() || bus.d_out_valid !== m_valid || bus.drop !== m_drop ||
          bus.d_out !== m_out || bus.d_out_slot !== SW'(m_slot)) begin
        errors++;
        $display("FAIL random_cycle%0d: got used=%h valid=%b drop=%b dout=%h slot=%0d expected used=%h valid=%b drop=%b dout=%h slot=%0d",
                 n, bus.used_pos, bus.d_out_valid, bus.drop, bus.d_out, bus.d_out_slot,
                 m_used_vec(), m_valid, m_drop, m_out, m_slot);
      end
    end
    rst = 1'b1;
    bus.we = '0;
  endtask

  initial begin
    bus.we = '0;
    bus.d_out_ready = 1'b0;
    for (int i = 0; i < LENGTH; i++) begin
      bus.d_in[i] = '0;
      m_data[i] = '0;
      m_used[i] = 1'b0;
    end
    m_out = '0; m_slot = 0; m_valid = 1'b0; m_drop = 1'b0; m_ptr = 0;
    test_reset();
    test_single_write();
    test_all_slots();
    test_backpressure();
    test_overflow();
    test_priority();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/piso_buffer.md
Name: piso_buffer

Overview:
Parallel-input, single-output buffer. It is the reverse of the single-input parallel-output buffer. Up to LENGTH producers each write their own slot in the same cycle. The block drains the occupied slots one per cycle through a registered valid/ready output port. It sits between parallel units such as execution lanes or cache ways and a single serial consumer such as a result bus or a fifo_queue.

Parameters:
WIDTH, 32, data width of each slot and of d_out
LENGTH, 8, number of slots; legal range 2..32

Ports:
clk  input  1  clock; all state updates on its rising edge
rst  input  1  reset, synchronous, active-low; sampled on the rising edge of clk
d_in  input  WIDTH x LENGTH (unpacked [LENGTH-1:0])  per-slot write data
we  input  LENGTH  per-slot write enable
used_pos  output  LENGTH  slot occupancy; bit i high means slot i holds unsent data
d_out  output  WIDTH  output data, from a register
d_out_slot  output  $clog2(LENGTH)  slot index that d_out came from
d_out_valid  output  1  d_out holds valid data
d_out_ready  input  1  consumer accepts d_out this cycle
drop  output  1  one-cycle pulse: a write to an occupied slot was discarded

Behaviour:
- Reset (rst==0 at an edge):
  - used_pos=0, d_out=0, d_out_slot=0, d_out_valid=0, drop=0, round-robin pointer=0.
  - Slot data is not cleared.
  - Reset overrides every other action in that cycle, including mid-transfer: a pending d_out is lost and writes in that cycle are ignored.
- Write:
  - Each slot is evaluated independently at the edge.
  - If we[i]==1 and used_pos[i]==0: slot i <= d_in[i] and used_pos[i] <= 1.
  - If we[i]==1 and used_pos[i]==1: the write is discarded, slot contents are unchanged, and drop==1 for the next cycle.
  - drop is the OR across all slots. It is registered and clears to 0 after one cycle unless a new discard occurs.
- Occupancy is sampled before the edge. A slot that is drained at edge N reads free in used_pos after edge N. A we[i] at edge N sees the pre-edge used_pos[i]==1 and is dropped. No same-edge refill of a slot.
- Output stage (one-entry skid register):
  - Load condition = (d_out_valid==0) or (d_out_valid==1 and d_out_ready==1).
  - On load, if any used_pos bit is 1: select slot s per the selection rule, then d_out <= slot[s], d_out_slot <= s, d_out_valid <= 1, used_pos[s] <= 0.
  - On load with no slot occupied: d_out_valid <= 0, and d_out/d_out_slot hold their old values.
  - While d_out_valid==1 and d_out_ready==0: d_out and d_out_slot are held stable.
- Latency and throughput:
  - A write at edge N sets used_pos at N. If selected at edge N+1, the data appears with d_out_valid high after N+1, so minimum write-to-output latency is 2 edges.
  - Sustained throughput is 1 word per cycle while slots are occupied and d_out_ready==1.
- Simultaneous write and drain of different slots in one edge is legal. Both take effect.
- Full buffer: all used_pos==1 plus d_out_valid==1 gives a capacity of LENGTH+1 words.
- Selection rule: set by the optional feature below. It only considers slots whose used_pos==1 before the edge, so data written at edge N is never selected at edge N.

Optional Feature:
PISO_ROUND_ROBIN_EN
- Defined:
  - A pointer rr_ptr (reset 0) names the highest-priority slot.
  - Selection is the first occupied slot searching rr_ptr, rr_ptr+1, ..., wrapping at LENGTH-1 to 0.
  - After each load from slot s, rr_ptr <= (s+1) mod LENGTH.
  - rr_ptr is unchanged when nothing is loaded.
- Undefined: fixed priority, lowest occupied index wins. No pointer state exists.

Test Plan:
1. Reset with rst=0 for 2 cycles while we=all 1s -> used_pos=0, d_out_valid=0, drop=0 after release; the next write is accepted normally.
2. LENGTH=8; at edge 0 write slot 5 with 32'hDEAD_BEEF and hold d_out_ready=1 -> d_out_valid=1 with d_out=32'hDEAD_BEEF and d_out_slot=5 after edge 1; valid drops after edge 2; used_pos[5]=0 after edge 1.
3. Write all 8 slots with values 0..7 in one cycle, d_out_ready=1 -> 8 consecutive valid beats with slots 0,1,...,7 (both builds, pointer starts at 0), then d_out_valid=0.
4. Backpressure: slots 2 and 6 occupied, d_out_ready=0 for 5 cycles -> d_out and d_out_slot held constant at slot 2; then ready=1 -> slot 6 on the next beat with no gap.
5. Overflow: slot 3 occupied and not yet drained, d_out stalled, we[3]=1 with 32'h1234 -> drop=1 for exactly one cycle and slot 3 data unchanged; a write to slot 3 in the cycle it drains is also dropped.
6. PISO_ROUND_ROBIN_EN: after slot 1 drains, slots 0 and 4 are occupied -> slot 4 is output before slot 0. Without the macro -> slot 0 is output first.
